// File: rtl/mul_seq_nk_if.sv
// mul_seq_nk_if: operand/result bundle for the iterative multiplier.
//   master : issues start/signed_mode/x/y, observes busy/done/p (datapath controller)
//   slave  : the multiplier itself
// Parameter N is the operand width; p is 2N bits wide.
interface mul_seq_nk_if #(
  parameter int unsigned N = 32
) ();
  logic             start;
  logic             signed_mode;
  logic [N-1:0]     x;
  logic [N-1:0]     y;
  logic             busy;
  logic             done;
  logic [2*N-1:0]   p;

  modport master (
    output start, signed_mode, x, y,
    input  busy, done, p
  );

  modport slave (
    input  start, signed_mode, x, y,
    output busy, done, p
  );
endinterface

// File: rtl/mul_seq_nk.sv
// mul_seq_nk: iterative N x N multiplier retiring K multiplier bits per clock.
// Signed operands are handled as sign + magnitude; the product is negated once at the end.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    slave side of mul_seq_nk_if:
//          start/signed_mode/x/y in (sampled only when not busy),
//          busy/done/p out (done is a one-cycle pulse, p held until the next result)
// Latency: done is high N/K+1 cycles after the accepting edge.
module mul_seq_nk #(
  parameter int unsigned N = 32,
  parameter int unsigned K = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  mul_seq_nk_if.slave  bus
);

  localparam int unsigned Iters = N / K;
  localparam int unsigned CntW  = (Iters > 1) ? $clog2(Iters) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(Iters - 1);
  localparam logic [CntW-1:0] CntOne  = CntW'(1);

  typedef enum logic [1:0] {StIdle, StCalc, StFix, StDone} state_e;

  state_e          state_q, state_d;
  logic            neg_q, neg_d;
  logic [N-1:0]    mcand_q, mcand_d;
  // Upper half accumulates partial products; lower half starts as |y| and is
  // shifted out K bits per iteration as product bits shift in from above.
  logic [2*N-1:0]  acc_q, acc_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2*N-1:0]  p_q, p_d;

  logic [N-1:0]     x_mag, y_mag;
  logic [N+K-1:0]   pp, sum_hi;
  logic [2*N+K-1:0] wide;
  logic [2*N-1:0]   acc_shift;
  logic             accept;

  assign accept = ((state_q == StIdle) || (state_q == StDone)) && bus.start;

  // -2^(N-1) negates to itself, which reads correctly as the unsigned magnitude 2^(N-1).
  assign x_mag = (bus.signed_mode && bus.x[N-1]) ? -bus.x : bus.x;
  assign y_mag = (bus.signed_mode && bus.y[N-1]) ? -bus.y : bus.y;

  // One shift-add step: |x| times the current K-bit digit, added into the upper half.
  assign pp        = {{K{1'b0}}, mcand_q} * {{N{1'b0}}, acc_q[K-1:0]};
  assign sum_hi    = {{K{1'b0}}, acc_q[2*N-1:N]} + pp;
  assign wide      = {sum_hi, acc_q[N-1:0]};
  assign acc_shift = wide[2*N+K-1:K];

  // State register and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      neg_q   <= 1'b0;
      mcand_q <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      p_q     <= '0;
    end else begin
      state_q <= state_d;
      neg_q   <= neg_d;
      mcand_q <= mcand_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      p_q     <= p_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  state_d = bus.start ? StCalc : StIdle;
      StCalc:  if (cnt_q == CntLast) state_d = StFix;
      StFix:   state_d = StDone;
      StDone:  state_d = bus.start ? StCalc : StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Datapath next-state
  always_comb begin
    neg_d   = neg_q;
    mcand_d = mcand_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    p_d     = p_q;
    if (accept) begin
      neg_d   = bus.signed_mode & (bus.x[N-1] ^ bus.y[N-1]);
      mcand_d = x_mag;
      acc_d   = {{N{1'b0}}, y_mag};
      cnt_d   = '0;
    end else if (state_q == StCalc) begin
      acc_d = acc_shift;
      cnt_d = cnt_q + CntOne;
    end else if (state_q == StFix) begin
      p_d = neg_q ? -acc_q : acc_q;
    end
  end

  // Outputs
  always_comb begin
    bus.busy = (state_q == StCalc) || (state_q == StFix);
    bus.done = (state_q == StDone);
    bus.p    = p_q;
  end

endmodule

// File: tb/tb_mul_seq_nk.sv
// Directed bench for mul_seq_nk: vector table on N=32/K=2, handshake and
// mid-operation reset sequences, and small-width sweeps for K=1 and K=4.
module tb_mul_seq_nk;

  logic clk;
  logic rst_n;

  mul_seq_nk_if #(.N(32)) b32 ();
  mul_seq_nk_if #(.N(8))  b8 ();
  mul_seq_nk_if #(.N(16)) b16 ();

  mul_seq_nk #(.N(32), .K(2)) u_dut32 (.clk(clk), .rst_n(rst_n), .bus(b32));
  mul_seq_nk #(.N(8),  .K(1)) u_dut8  (.clk(clk), .rst_n(rst_n), .bus(b8));
  mul_seq_nk #(.N(16), .K(4)) u_dut16 (.clk(clk), .rst_n(rst_n), .bus(b16));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int overlap  = 0;

  typedef struct {
    logic [31:0] x;
    logic [31:0] y;
    logic        sm;
    logic [63:0] exp;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic run32(input logic [31:0] xa, input logic [31:0] ya, input logic sm,
                       output logic [63:0] pr, output int lat);
    @(negedge clk);
    b32.start = 1'b1; b32.x = xa; b32.y = ya; b32.signed_mode = sm;
    @(negedge clk);
    b32.start = 1'b0;
    lat = 0;
    while (!b32.done && lat < 100) begin
      @(negedge clk);
      lat++;
      if (b32.busy && b32.done) overlap++;
    end
    pr = b32.p;
  endtask

  task automatic run8(input logic [7:0] xa, input logic [7:0] ya, input logic sm,
                      output logic [15:0] pr, output int lat);
    @(negedge clk);
    b8.start = 1'b1; b8.x = xa; b8.y = ya; b8.signed_mode = sm;
    @(negedge clk);
    b8.start = 1'b0;
    lat = 0;
    while (!b8.done && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    pr = b8.p;
  endtask

  task automatic run16(input logic [15:0] xa, input logic [15:0] ya, input logic sm,
                       output logic [31:0] pr, output int lat);
    @(negedge clk);
    b16.start = 1'b1; b16.x = xa; b16.y = ya; b16.signed_mode = sm;
    @(negedge clk);
    b16.start = 1'b0;
    lat = 0;
    while (!b16.done && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    pr = b16.p;
  endtask

  initial begin
    logic [63:0] pr;
    logic [63:0] p1, p2, plast;
    logic [15:0] pr8;
    logic [31:0] pr16;
    logic [7:0]  corner8[4];
    int lat, c, d1, d2, ndone, pchg, late_done;

    vecs[0]  = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 64'hFFFFFFFE00000001};
    vecs[1]  = '{32'h80000000, 32'h80000000, 1'b1, 64'h4000000000000000};
    vecs[2]  = '{32'hFFFFFFFF, 32'h00000005, 1'b1, 64'hFFFFFFFFFFFFFFFB};
    vecs[3]  = '{32'hFFFFFFFF, 32'h00000005, 1'b0, 64'h00000004FFFFFFFB};
    vecs[4]  = '{32'h00000000, 32'h12345678, 1'b1, 64'h0000000000000000};
    vecs[5]  = '{32'h80000000, 32'h00000001, 1'b1, 64'hFFFFFFFF80000000};
    vecs[6]  = '{32'h80000000, 32'hFFFFFFFF, 1'b1, 64'h0000000080000000};
    vecs[7]  = '{32'h00000003, 32'h00000007, 1'b0, 64'h0000000000000015};
    vecs[8]  = '{32'h7FFFFFFF, 32'h7FFFFFFF, 1'b1, 64'h3FFFFFFF00000001};
    vecs[9]  = '{32'hFFFFFFFE, 32'h00000003, 1'b1, 64'hFFFFFFFFFFFFFFFA};
    vecs[10] = '{32'h00010000, 32'h00010000, 1'b0, 64'h0000000100000000};
    vecs[11] = '{32'hFFFFFFFF, 32'h00000000, 1'b1, 64'h0000000000000000};

    corner8[0] = 8'h00; corner8[1] = 8'h7F; corner8[2] = 8'h80; corner8[3] = 8'hFF;

    rst_n = 1'b0;
    b32.start = 1'b0; b32.signed_mode = 1'b0; b32.x = '0; b32.y = '0;
    b8.start  = 1'b0; b8.signed_mode  = 1'b0; b8.x  = '0; b8.y  = '0;
    b16.start = 1'b0; b16.signed_mode = 1'b0; b16.x = '0; b16.y = '0;
    #1;
    chk("reset_busy", 64'(b32.busy), 64'd0);
    chk("reset_done", 64'(b32.done), 64'd0);
    chk("reset_p",    b32.p,         64'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Vector table
    for (int i = 0; i < 12; i++) begin
      run32(vecs[i].x, vecs[i].y, vecs[i].sm, pr, lat);
      chk($sformatf("vec%0d_p", i), pr, vecs[i].exp);
      chk($sformatf("vec%0d_lat", i), 64'(lat), 64'd17);
    end

    // Handshake: noise on inputs while busy, then start accepted in the DONE cycle
    @(negedge clk);
    b32.start = 1'b1; b32.x = 32'd3; b32.y = 32'd7; b32.signed_mode = 1'b0;
    c = 0; d1 = -1; d2 = -1; ndone = 0; pchg = 0; p1 = '0; p2 = '0;
    plast = b32.p;
    while (d2 < 0 && c < 80) begin
      @(negedge clk);
      c++;
      if (b32.busy && b32.done) overlap++;
      if (b32.p !== plast && !b32.done) pchg++;
      plast = b32.p;
      if (b32.done) begin
        ndone++;
        if (d1 < 0) begin
          d1 = c; p1 = b32.p;
          b32.start = 1'b1; b32.x = 32'd6; b32.y = 32'd9; b32.signed_mode = 1'b0;
        end else begin
          d2 = c; p2 = b32.p;
        end
      end else if (d1 >= 0) begin
        b32.start = 1'b0;
      end else if (b32.busy) begin
        b32.start = ~b32.start;
        b32.x = $urandom; b32.y = $urandom; b32.signed_mode = 1'($urandom);
      end
    end
    b32.start = 1'b0;
    chk("hs_first_p",    p1,              64'd21);
    chk("hs_first_lat",  64'(d1),         64'd18);
    chk("hs_second_p",   p2,              64'd54);
    chk("hs_b2b_gap",    64'(d2 - d1),    64'd18);
    chk("hs_done_count", 64'(ndone),      64'd2);
    chk("hs_p_stable",   64'(pchg),       64'd0);

    // Reset mid-operation
    @(negedge clk);
    b32.start = 1'b1; b32.x = 32'd1000; b32.y = 32'd1000; b32.signed_mode = 1'b0;
    @(negedge clk);
    b32.start = 1'b0;
    repeat (4) @(negedge clk);
    chk("rst_mid_busy_before", 64'(b32.busy), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_busy", 64'(b32.busy), 64'd0);
    chk("rst_mid_done", 64'(b32.done), 64'd0);
    chk("rst_mid_p",    b32.p,         64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    late_done = 0;
    repeat (30) begin
      @(negedge clk);
      if (b32.done || b32.busy) late_done++;
    end
    chk("rst_no_done", 64'(late_done), 64'd0);
    run32(32'd2, 32'd3, 1'b0, pr, lat);
    chk("post_rst_p",   pr,        64'd6);
    chk("post_rst_lat", 64'(lat),  64'd17);

    chk("busy_done_overlap", 64'(overlap), 64'd0);

    // N=8, K=1: corner grid then random pairs, both modes
    for (int i = 0; i < 64; i++) begin
      logic [7:0]  xa, ya;
      logic [15:0] xe, ye, e;
      logic        sm;
      if (i < 32) begin
        xa = corner8[i % 4]; ya = corner8[(i / 4) % 4]; sm = 1'(i / 16);
      end else begin
        xa = 8'($urandom); ya = 8'($urandom); sm = 1'($urandom);
      end
      xe = sm ? {{8{xa[7]}}, xa} : {8'h00, xa};
      ye = sm ? {{8{ya[7]}}, ya} : {8'h00, ya};
      e  = xe * ye;
      run8(xa, ya, sm, pr8, lat);
      chk($sformatf("n8k1_%0d_p", i), 64'(pr8), 64'(e));
      chk($sformatf("n8k1_%0d_lat", i), 64'(lat), 64'd9);
    end

    // N=16, K=4: random pairs, both modes
    for (int i = 0; i < 64; i++) begin
      logic [15:0] xa, ya;
      logic [31:0] xe, ye, e;
      logic        sm;
      xa = 16'($urandom); ya = 16'($urandom); sm = 1'($urandom);
      if (i == 0) begin xa = 16'h8000; ya = 16'h8000; sm = 1'b1; end
      if (i == 1) begin xa = 16'hFFFF; ya = 16'hFFFF; sm = 1'b0; end
      xe = sm ? {{16{xa[15]}}, xa} : {16'h0000, xa};
      ye = sm ? {{16{ya[15]}}, ya} : {16'h0000, ya};
      e  = xe * ye;
      run16(xa, ya, sm, pr16, lat);
      chk($sformatf("n16k4_%0d_p", i), 64'(pr16), 64'(e));
      chk($sformatf("n16k4_%0d_lat", i), 64'(lat), 64'd5);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
